// File: rtl/pwm_timer_if.sv
// Control and status bundle for pwm_timer: clock select, mode, compare
// value write port, and the counter/waveform/overflow outputs.
interface pwm_timer_if;
  logic [2:0] cs;
  logic       mode;
  logic [1:0] com;
  logic       ocr_wr;
  logic [7:0] ocr_data;
  logic       pwm_gen;
  logic       tov;
  logic [7:0] tcnt;

  modport master (
    output cs, mode, com, ocr_wr, ocr_data,
    input  pwm_gen, tov, tcnt
  );

  modport slave (
    input  cs, mode, com, ocr_wr, ocr_data,
    output pwm_gen, tov, tcnt
  );
endinterface

// File: rtl/pwm_timer.sv
// 8-bit PWM timer with 10-bit prescaler, fast PWM and optional phase-correct
// PWM (enabled by defining PWM_PHASE_CORRECT_EN).
module pwm_timer (
  input logic        clk,
  input logic        rst,
  pwm_timer_if.slave bus
);

  logic [9:0] presc;
  logic [2:0] cs_q;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [7:0] ocr_buf;
  logic [7:0] ocr_active;
  logic       stopped;
  logic       cs_chg;
  logic [9:0] limit;
  logic       tick;
  logic       upd;
  logic       ovf;
  logic       cmp;

  function automatic logic [9:0] presc_limit(input logic [2:0] sel);
    case (sel)
      3'b001:  return 10'd0;
      3'b010:  return 10'd7;
      3'b011:  return 10'd63;
      3'b100:  return 10'd255;
      3'b101:  return 10'd1023;
      default: return 10'd0;
    endcase
  endfunction

  assign stopped = !(bus.cs inside {[3'b001:3'b101]});
  assign cs_chg  = (bus.cs != cs_q);
  assign limit   = presc_limit(bus.cs);
  assign tick    = !stopped && !cs_chg && (presc == limit);
  assign cmp     = (cnt < ocr_active);
  assign bus.tcnt = cnt;

`ifdef PWM_PHASE_CORRECT_EN
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;
  dir_e dir, dir_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir <= UP;
    else     dir <= dir_nxt;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  // NOTE: every output of this block is defaulted first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_nxt = cnt;
    upd     = 1'b0;
    ovf     = 1'b0;
`ifdef PWM_PHASE_CORRECT_EN
    dir_nxt = dir;
    if (!bus.mode) dir_nxt = UP;
`endif
    if (tick) begin
`ifdef PWM_PHASE_CORRECT_EN
      if (bus.mode) begin
        // Turnaround happens on the tick taken at either extreme.
        if (dir == UP) begin
          if (cnt == 8'hFF) begin
            dir_nxt = DOWN;
            cnt_nxt = 8'hFE;
            upd     = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          if (cnt == 8'h00) begin
            dir_nxt = UP;
            cnt_nxt = 8'h01;
            ovf     = 1'b1;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
      end else
`endif
      begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == 8'hFF) begin
          upd = 1'b1;
          ovf = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= 10'd0;
      cs_q  <= 3'b000;
      cnt   <= 8'd0;
    end else begin
      cs_q <= bus.cs;
      cnt  <= cnt_nxt;
      if (cs_chg)        presc <= 10'd0;
      else if (!stopped) presc <= (presc == limit) ? 10'd0 : presc + 10'd1;
    end
  end

  // A write landing on the update point bypasses the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocr_buf    <= 8'd0;
      ocr_active <= 8'd0;
    end else begin
      if (bus.ocr_wr) ocr_buf <= bus.ocr_data;
      if (stopped && bus.ocr_wr) ocr_active <= bus.ocr_data;
      else if (upd)              ocr_active <= bus.ocr_wr ? bus.ocr_data : ocr_buf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pwm_gen <= 1'b0;
      bus.tov     <= 1'b0;
    end else begin
      bus.tov <= ovf;
      case (bus.com)
        2'b10:   bus.pwm_gen <= cmp;
        2'b11:   bus.pwm_gen <= ~cmp;
        default: bus.pwm_gen <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_timer.sv
// Directed self-checking bench for pwm_timer; samples on the falling edge.
module tb_pwm_timer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   n;
  int   highs;
  int   tovs;
  int   maxc;
  logic [7:0] t0;

  pwm_timer_if bus ();

  pwm_timer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_ocr(input logic [7:0] v);
    bus.ocr_wr   = 1'b1;
    bus.ocr_data = v;
    @(negedge clk);
    bus.ocr_wr   = 1'b0;
  endtask

  task automatic wait_tov(input string tag, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.tov !== 1'b1 && k < budget);
    if (bus.tov !== 1'b1) check(tag, 0, 1);
  endtask

  task automatic wait_tcnt(input string tag, input logic [7:0] v, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.tcnt !== v && k < budget);
    if (bus.tcnt !== v) check(tag, bus.tcnt, v);
  endtask

  // Window includes the current sample; returns positioned at the next one.
  task automatic measure(input int len, output int hi, output int ov, output int mx);
    hi = 0; ov = 0; mx = 0;
    for (int i = 0; i < len; i++) begin
      hi += int'(bus.pwm_gen);
      ov += int'(bus.tov);
      if (int'(bus.tcnt) > mx) mx = int'(bus.tcnt);
      @(negedge clk);
    end
  endtask

  task automatic count_change(input int budget, output int k);
    logic [7:0] start;
    start = bus.tcnt;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.tcnt === start && k < budget);
  endtask

  initial begin
    rst = 1'b1;
    bus.cs = 3'b000;
    bus.mode = 1'b0;
    bus.com = 2'b00;
    bus.ocr_wr = 1'b0;
    bus.ocr_data = 8'd0;
    #12;
    check("reset_tcnt", bus.tcnt, 0);
    check("reset_pwm", bus.pwm_gen, 0);
    check("reset_tov", bus.tov, 0);
    @(negedge clk);
    rst = 1'b0;

    // Stopped: compare write goes straight to the active register.
    bus.com = 2'b10;
    write_ocr(8'd64);
    @(negedge clk);
    check("stop_ocr_track", bus.pwm_gen, 1);
    repeat (10) @(negedge clk);
    check("stop_hold", bus.tcnt, 0);

    // /1, duty 64 of 256.
    bus.cs = 3'b001;
    wait_tov("tov_timeout_a", 600);
    measure(256, highs, tovs, maxc);
    check("duty64_high", highs, 64);
    check("duty64_tov", tovs, 1);
    check("period256_tcnt", bus.tcnt, 0);
    check("period256_tov", bus.tov, 1);
    wait_tcnt("wait64", 8'd64, 600);
    check("edge_hi", bus.pwm_gen, 1);
    @(negedge clk);
    check("edge_lo", bus.pwm_gen, 0);

    // Buffered update: new duty only after wrap.
    wait_tcnt("wait100", 8'd100, 600);
    write_ocr(8'd200);
    wait_tcnt("wait150", 8'd150, 600);
    check("ocr_defer", bus.pwm_gen, 0);
    wait_tov("tov_timeout_b", 600);
    measure(256, highs, tovs, maxc);
    check("duty200_high", highs, 200);
    write_ocr(8'd0);
    wait_tov("tov_timeout_c", 600);
    measure(256, highs, tovs, maxc);
    check("ocr0_high", highs, 0);

    // OCR=255, then inverting.
    write_ocr(8'd255);
    wait_tov("tov_timeout_d", 600);
    measure(256, highs, tovs, maxc);
    check("ocr255_fast_high", highs, 255);
    bus.com = 2'b11;
    wait_tov("tov_timeout_e", 600);
    measure(256, highs, tovs, maxc);
    check("ocr255_inv_high", highs, 1);
    wait_tcnt("wait255", 8'd255, 600);
    bus.com = 2'b00;
    @(negedge clk);
    check("com00_low", bus.pwm_gen, 0);

    // Prescaler: cs change clears on that edge, tick follows after a full divide.
    bus.cs = 3'b010;
    count_change(100, n);
    check("div8_first", n, 9);
    t0 = bus.tcnt;
    count_change(100, n);
    check("div8_steady", n, 8);
    check("div8_step", bus.tcnt, t0 + 8'd1);
    repeat (3) @(negedge clk);
    bus.cs = 3'b011;
    count_change(200, n);
    check("div64_switch", n, 65);

    // Reset mid-period.
    bus.com = 2'b10;
    bus.cs = 3'b001;
    wait_tcnt("wait77", 8'd77, 600);
    check("pre_rst_pwm", bus.pwm_gen, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_tcnt", bus.tcnt, 0);
    check("rst_pwm", bus.pwm_gen, 0);
    check("rst_tov", bus.tov, 0);
    @(negedge clk);
    rst = 1'b0;
    count_change(10, n);
    check("rst_first_tick_lat", n, 2);
    check("rst_first_tick_val", bus.tcnt, 1);

    // Mode select: phase-correct when compiled in, ignored otherwise.
    bus.cs = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    write_ocr(8'd128);
    bus.com = 2'b10;
    bus.mode = 1'b1;
    bus.cs = 3'b001;
`ifdef PWM_PHASE_CORRECT_EN
    wait_tov("tov_timeout_pc", 1200);
    check("pc_bottom_tcnt", bus.tcnt, 1);
    measure(510, highs, tovs, maxc);
    check("pc_high", highs, 255);
    check("pc_tov", tovs, 1);
    check("pc_max", maxc, 255);
    check("pc_period", bus.tcnt, 1);
`else
    wait_tov("tov_timeout_m", 600);
    measure(256, highs, tovs, maxc);
    check("mode_ign_high", highs, 128);
    check("mode_ign_tov", tovs, 1);
    check("mode_ign_period", bus.tcnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
